// File: rtl/v_pipe_update_mc.sv
// v_pipe_update_mc
//   This block pipelines read-modify-write updates to a per-product state table.
//   Each table entry is {vld, key, size}, and the table itself lives outside the
//   block. After reset, the INIT state writes zeros to every entry. The RUN state
//   then accepts one update per cycle.
//
//   Ports
//     clk, rst_n          clock, async active-low reset
//     i_upd_*             update bus (vld, prod_id, cmd, key, size)
//     o_upd_rdy           high only in RUN
//     o_state_ren/raddr   table read request; i_state_rdata is valid the next cycle
//     o_state_*_r         table write port (registered)
//     o_rsp_*_r           per-update response (registered)
//     o_err_sticky_r      set by any error response, cleared only by reset
//
//   state | meaning
//   INIT  | zero-fill table addresses 0..2^ID_W-1, updates dropped
//   RUN   | accept updates, pipeline active
module v_pipe_update_mc #(
  parameter int ID_W   = 4,
  parameter int KEY_W  = 32,
  parameter int SIZE_W = 16,
  localparam int STATE_W = 1 + KEY_W + SIZE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_upd_vld,
  input  logic [ID_W-1:0]    i_upd_prod_id,
  input  logic [1:0]         i_upd_cmd,
  input  logic [KEY_W-1:0]   i_upd_key,
  input  logic [SIZE_W-1:0]  i_upd_size,
  output logic               o_upd_rdy,
  output logic               o_state_ren,
  output logic [ID_W-1:0]    o_state_raddr,
  input  logic [STATE_W-1:0] i_state_rdata,
  output logic               o_state_wen_r,
  output logic [ID_W-1:0]    o_state_waddr_r,
  output logic [STATE_W-1:0] o_state_wdata_r,
  output logic               o_rsp_vld_r,
  output logic [ID_W-1:0]    o_rsp_prod_id_r,
  output logic               o_rsp_hit_r,
  output logic               o_rsp_err_r,
  output logic [SIZE_W-1:0]  o_rsp_size_r,
  output logic               o_err_sticky_r
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [1:0] CMD_CLR = 2'b00;
  localparam logic [1:0] CMD_ADD = 2'b01;
  localparam logic [1:0] CMD_INC = 2'b10;
  localparam int         DEPTH   = 1 << ID_W;
  localparam logic [ID_W:0] INIT_END = DEPTH[ID_W:0];

  logic [0:0]  state;
  logic [ID_W:0] init_cnt;
  logic        init_wr;

  // S1: accepted update
  logic              s1_vld;
  logic [ID_W-1:0]   s1_id;
  logic [1:0]        s1_cmd;
  logic [KEY_W-1:0]  s1_key;
  logic [SIZE_W-1:0] s1_size;
  // read-issue stage: the read request comes from flops so that rdata arrives while the op is in S2
  logic [1:0]        rq_cmd;
  logic [KEY_W-1:0]  rq_key;
  logic [SIZE_W-1:0] rq_size;
  // S2: combine
  logic              s2_vld;
  logic [ID_W-1:0]   s2_id;
  logic [1:0]        s2_cmd;
  logic [KEY_W-1:0]  s2_key;
  logic [SIZE_W-1:0] s2_size;
  // one-deep copy of the previous cycle's table write
  logic              lw_vld;
  logic [ID_W-1:0]   lw_addr;
  logic [STATE_W-1:0] lw_data;

  logic [STATE_W-1:0] old_entry, new_entry;
  logic               old_vld, key_hit, new_hit, new_err;
  logic [KEY_W-1:0]   old_key;
  logic [SIZE_W-1:0]  old_size, sat_size;
  logic [SIZE_W:0]    sum;

  assign o_upd_rdy = (state == ST_RUN);
  assign init_wr   = (state == ST_INIT) && (init_cnt != INIT_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else if (state == ST_INIT) begin
      if (init_cnt == INIT_END) state <= ST_RUN;
      else                      init_cnt <= init_cnt + 1'b1;
    end
  end

  // The S3 write is one cycle from reaching the table, and the last-write copy
  // covers a read that coincides with the table write. Older writes are already
  // visible in rdata.
  always_comb begin
    if (o_state_wen_r && (o_state_waddr_r == s2_id))
      old_entry = o_state_wdata_r;
    else if (lw_vld && (lw_addr == s2_id))
      old_entry = lw_data;
    else
      old_entry = i_state_rdata;
  end

  always_comb begin
    old_vld  = old_entry[STATE_W-1];
    old_key  = old_entry[SIZE_W +: KEY_W];
    old_size = old_entry[SIZE_W-1:0];
    key_hit  = old_vld && (old_key == s2_key);
    sum      = {1'b0, old_size} + {1'b0, s2_size};
    sat_size = sum[SIZE_W] ? {SIZE_W{1'b1}} : sum[SIZE_W-1:0];
    new_entry = old_entry;
    new_hit   = key_hit;
    new_err   = 1'b0;
    case (s2_cmd)
      CMD_CLR: begin
        new_entry = '0;
        new_hit   = old_vld;
      end
      CMD_ADD: new_entry = {1'b1, s2_key, s2_size};
      CMD_INC: begin
        if (key_hit) new_entry = {1'b1, old_key, sat_size};
        else         new_err   = 1'b1;
      end
      default: begin
        if (!key_hit)               new_err   = 1'b1;
        else if (old_size > s2_size) new_entry = {1'b1, old_key, old_size - s2_size};
        else                        new_entry = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld         <= 1'b0;
      o_state_ren    <= 1'b0;
      s2_vld         <= 1'b0;
      o_state_wen_r  <= 1'b0;
      o_rsp_vld_r    <= 1'b0;
      lw_vld         <= 1'b0;
      o_err_sticky_r <= 1'b0;
    end else begin
      s1_vld        <= i_upd_vld && o_upd_rdy;
      o_state_ren   <= s1_vld;
      s2_vld        <= o_state_ren;
      o_state_wen_r <= init_wr || s2_vld;
      o_rsp_vld_r   <= s2_vld;
      lw_vld        <= o_state_wen_r;
      if (s2_vld && new_err) o_err_sticky_r <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    s1_id         <= i_upd_prod_id;
    s1_cmd        <= i_upd_cmd;
    s1_key        <= i_upd_key;
    s1_size       <= i_upd_size;
    o_state_raddr <= s1_id;
    rq_cmd        <= s1_cmd;
    rq_key        <= s1_key;
    rq_size       <= s1_size;
    s2_id         <= o_state_raddr;
    s2_cmd        <= rq_cmd;
    s2_key        <= rq_key;
    s2_size       <= rq_size;
    if (init_wr) begin
      o_state_waddr_r <= init_cnt[ID_W-1:0];
      o_state_wdata_r <= '0;
    end else begin
      o_state_waddr_r <= s2_id;
      o_state_wdata_r <= new_entry;
    end
    o_rsp_prod_id_r <= s2_id;
    o_rsp_hit_r     <= new_hit;
    o_rsp_err_r     <= new_err;
    o_rsp_size_r    <= new_entry[SIZE_W-1:0];
    lw_addr         <= o_state_waddr_r;
    lw_data         <= o_state_wdata_r;
  end

endmodule

// File: tb/tb_v_pipe_update_mc.sv
// Testbench for v_pipe_update_mc. It models the external table as a memory
// with registered read and old-data-on-collision behaviour. A serial reference
// model computes the expected write and response for each accepted update, and
// those results are queued and compared when the DUT responds.
module tb_v_pipe_update_mc;
  localparam int ID_W    = 4;
  localparam int KEY_W   = 32;
  localparam int SIZE_W  = 16;
  localparam int STATE_W = 1 + KEY_W + SIZE_W;
  localparam int DEPTH   = 1 << ID_W;
  localparam int SMAX    = (1 << SIZE_W) - 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               i_upd_vld = 1'b0;
  logic [ID_W-1:0]    i_upd_prod_id = '0;
  logic [1:0]         i_upd_cmd = '0;
  logic [KEY_W-1:0]   i_upd_key = '0;
  logic [SIZE_W-1:0]  i_upd_size = '0;
  logic               o_upd_rdy;
  logic               o_state_ren;
  logic [ID_W-1:0]    o_state_raddr;
  logic [STATE_W-1:0] i_state_rdata;
  logic               o_state_wen_r;
  logic [ID_W-1:0]    o_state_waddr_r;
  logic [STATE_W-1:0] o_state_wdata_r;
  logic               o_rsp_vld_r;
  logic [ID_W-1:0]    o_rsp_prod_id_r;
  logic               o_rsp_hit_r;
  logic               o_rsp_err_r;
  logic [SIZE_W-1:0]  o_rsp_size_r;
  logic               o_err_sticky_r;

  v_pipe_update_mc #(.ID_W(ID_W), .KEY_W(KEY_W), .SIZE_W(SIZE_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_upd_vld(i_upd_vld), .i_upd_prod_id(i_upd_prod_id), .i_upd_cmd(i_upd_cmd),
    .i_upd_key(i_upd_key), .i_upd_size(i_upd_size), .o_upd_rdy(o_upd_rdy),
    .o_state_ren(o_state_ren), .o_state_raddr(o_state_raddr), .i_state_rdata(i_state_rdata),
    .o_state_wen_r(o_state_wen_r), .o_state_waddr_r(o_state_waddr_r),
    .o_state_wdata_r(o_state_wdata_r), .o_rsp_vld_r(o_rsp_vld_r),
    .o_rsp_prod_id_r(o_rsp_prod_id_r), .o_rsp_hit_r(o_rsp_hit_r), .o_rsp_err_r(o_rsp_err_r),
    .o_rsp_size_r(o_rsp_size_r), .o_err_sticky_r(o_err_sticky_r)
  );

  always #5 clk = ~clk;

  // external table: registered read, read-during-write returns old data
  logic [STATE_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (o_state_ren)   i_state_rdata <= mem[o_state_raddr];
    if (o_state_wen_r) mem[o_state_waddr_r] <= o_state_wdata_r;
  end

  typedef struct {
    logic [ID_W-1:0]    id;
    logic               hit;
    logic               err;
    logic [SIZE_W-1:0]  size;
    logic [STATE_W-1:0] wdata;
    int                 acc;
  } exp_t;

  exp_t               expq[$];
  exp_t               got_e;
  logic [STATE_W-1:0] ref_mem [DEPTH];
  logic               exp_sticky = 1'b0;
  int                 n_checks = 0;
  int                 n_errors = 0;
  int                 cyc = 0;
  bit                 mon_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic model(input logic [1:0] cmd, input logic [ID_W-1:0] id,
                       input logic [KEY_W-1:0] key, input logic [SIZE_W-1:0] sz,
                       output exp_t e);
    logic [STATE_W-1:0] o, n;
    logic               ov, kh;
    logic [KEY_W-1:0]   ok;
    logic [SIZE_W-1:0]  os;
    int                 s;
    o  = ref_mem[id];
    ov = o[STATE_W-1];
    ok = o[SIZE_W +: KEY_W];
    os = o[SIZE_W-1:0];
    kh = ov && (ok == key);
    n  = o;
    e.hit = kh;
    e.err = 1'b0;
    case (cmd)
      2'd0: begin n = '0; e.hit = ov; end
      2'd1: n = {1'b1, key, sz};
      2'd2: begin
        if (kh) begin
          s = int'(os) + int'(sz);
          if (s > SMAX) s = SMAX;
          n = {1'b1, ok, SIZE_W'(s)};
        end else e.err = 1'b1;
      end
      default: begin
        if (kh) begin
          s = int'(os) - int'(sz);
          if (s <= 0) n = '0;
          else        n = {1'b1, ok, SIZE_W'(s)};
        end else e.err = 1'b1;
      end
    endcase
    ref_mem[id] = n;
    e.id    = id;
    e.size  = n[SIZE_W-1:0];
    e.wdata = n;
    e.acc   = 0;
  endtask

  // called at a negedge while o_upd_rdy=1; returns at the next negedge with vld still high
  task automatic send(input logic [1:0] cmd, input logic [ID_W-1:0] id,
                      input logic [KEY_W-1:0] key, input logic [SIZE_W-1:0] sz);
    exp_t e;
    i_upd_vld = 1'b1;
    i_upd_cmd = cmd;
    i_upd_prod_id = id;
    i_upd_key = key;
    i_upd_size = sz;
    model(cmd, id, key, sz, e);
    @(posedge clk);
    #1;
    e.acc = cyc;
    expq.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    i_upd_vld = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    i_upd_vld = 1'b0;
    while (expq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 64'(expq.size()), 0);
  endtask

  task automatic init_check();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      check("init_wen", o_state_wen_r, 1);
      check("init_waddr", o_state_waddr_r, i);
      check("init_wdata", o_state_wdata_r, 0);
      check("init_rdy", o_upd_rdy, 0);
      check("init_rsp_vld", o_rsp_vld_r, 0);
    end
    i_upd_vld = 1'b0;
    @(negedge clk);
    check("run_rdy", o_upd_rdy, 1);
    check("run_wen_idle", o_state_wen_r, 0);
  endtask

  task automatic reset_check();
    check("rst_wen", o_state_wen_r, 0);
    check("rst_rsp_vld", o_rsp_vld_r, 0);
    check("rst_rdy", o_upd_rdy, 0);
    check("rst_sticky", o_err_sticky_r, 0);
    check("rst_ren", o_state_ren, 0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      check("wen_vs_rsp", o_state_wen_r, o_rsp_vld_r);
      if (o_rsp_vld_r) begin
        if (expq.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          got_e = expq.pop_front();
          exp_sticky = exp_sticky | got_e.err;
          check("rsp_id", o_rsp_prod_id_r, got_e.id);
          check("rsp_hit", o_rsp_hit_r, got_e.hit);
          check("rsp_err", o_rsp_err_r, got_e.err);
          check("rsp_size", o_rsp_size_r, got_e.size);
          check("wr_addr", o_state_waddr_r, got_e.id);
          check("wr_data", o_state_wdata_r, got_e.wdata);
          check("rsp_latency", 64'(cyc - got_e.acc), 3);
          check("err_sticky", o_err_sticky_r, exp_sticky);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    repeat (3) @(negedge clk);
    reset_check();

    // an update presented during INIT must be dropped
    i_upd_vld = 1'b1;
    i_upd_cmd = 2'd1;
    i_upd_prod_id = 4'd5;
    i_upd_key = 32'h55;
    i_upd_size = 16'd9;
    rst_n = 1'b1;
    init_check();
    mon_en = 1'b1;

    // ADD then INC back-to-back: S3 forwarding
    send(2'd1, 4'd3, 32'hA5, 16'd10);
    send(2'd2, 4'd3, 32'hA5, 16'd5);
    idle(6);
    // saturating INC, one idle cycle between: last-write forwarding
    send(2'd1, 4'd3, 32'hA5, 16'h0020);
    idle(1);
    send(2'd2, 4'd3, 32'hA5, 16'hFFF0);
    idle(6);
    // DEC to zero clears the entry, then INC misses
    send(2'd1, 4'd3, 32'hA5, 16'd15);
    idle(2);
    send(2'd3, 4'd3, 32'hA5, 16'd20);
    send(2'd2, 4'd3, 32'hA5, 16'd1);
    idle(6);
    // ids 1,2,1 back-to-back
    send(2'd1, 4'd1, 32'h11, 16'd100);
    send(2'd1, 4'd2, 32'h22, 16'd7);
    send(2'd2, 4'd1, 32'h11, 16'd50);
    idle(4);
    // dropped INIT update left id5 empty; CLR hit/miss; exact DEC to zero
    send(2'd2, 4'd5, 32'h55, 16'd1);
    send(2'd0, 4'd2, 32'h0, 16'd0);
    send(2'd0, 4'd7, 32'h0, 16'd0);
    send(2'd3, 4'd1, 32'h11, 16'd150);
    send(2'd2, 4'd1, 32'h12, 16'd1);
    idle(4);
    // random mix on a few ids with random spacing
    for (int i = 0; i < 60; i++) begin
      send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
           ($urandom_range(0, 3) == 0) ? 32'h5A : 32'hA5,
           16'($urandom_range(0, 3) == 0 ? $urandom_range(60000, 65535) : $urandom_range(0, 40)));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    drain();

    // reset with three ops in flight
    send(2'd1, 4'd4, 32'hA5, 16'd3);
    send(2'd2, 4'd4, 32'hA5, 16'd4);
    send(2'd1, 4'd6, 32'h66, 16'd8);
    mon_en = 1'b0;
    rst_n = 1'b0;
    i_upd_vld = 1'b0;
    expq.delete();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    exp_sticky = 1'b0;
    repeat (3) @(negedge clk);
    reset_check();
    rst_n = 1'b1;
    init_check();
    mon_en = 1'b1;
    send(2'd2, 4'd4, 32'hA5, 16'd1);
    send(2'd1, 4'd4, 32'hA5, 16'd3);
    send(2'd2, 4'd4, 32'hA5, 16'd4);
    drain();
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/v_pipe_update_mc.md
V_PIPE_UPDATE_MC -- requirements
Module: v_pipe_update_mc

Interface
REQ-001 The block SHALL have parameter ID_W, default 4, meaning product-id width; the state table depth is 2^ID_W entries and the table address equals prod_id.
REQ-002 The block SHALL have parameter KEY_W, default 32, meaning key width.
REQ-003 The block SHALL have parameter SIZE_W, default 16, meaning size width; STATE_W = 1+KEY_W+SIZE_W, packed as {vld, key, size} with vld at the MSB.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all flops sample on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have the update bus: i_upd_vld (in, 1), i_upd_prod_id (in, ID_W), i_upd_cmd (in, 2), i_upd_key (in, KEY_W), i_upd_size (in, SIZE_W).
REQ-007 The block SHALL have port o_upd_rdy, output, 1 bit: the block accepts updates; it is high only in state RUN.
REQ-008 The block SHALL have the state read port: o_state_ren (out, 1), o_state_raddr (out, ID_W) and i_state_rdata (in, STATE_W); rdata is valid one cycle after ren, and a read-during-write to the same address returns old data.
REQ-009 The block SHALL have the state write port: o_state_wen_r (out, 1), o_state_waddr_r (out, ID_W), o_state_wdata_r (out, STATE_W); all three are driven directly from flops.
REQ-010 The block SHALL have the response port: o_rsp_vld_r (1), o_rsp_prod_id_r (ID_W), o_rsp_hit_r (1; old entry valid and key matched), o_rsp_err_r (1), o_rsp_size_r (SIZE_W; new size); all are outputs driven directly from flops.
REQ-011 The block SHALL have port o_err_sticky_r, output, 1 bit: set by any error response and cleared only by reset.

Function
REQ-012 The block SHALL implement a two-state controller with states INIT and RUN; it enters INIT on reset.
REQ-013 In INIT, the block SHALL write STATE_W'0 to addresses 0..2^ID_W-1, one per cycle in ascending order, via the write port, then move to RUN on the cycle after the last address is written.
REQ-014 In INIT, o_upd_rdy SHALL be 0 and o_rsp_vld_r SHALL be 0; an update arriving while o_upd_rdy=0 SHALL be dropped without side effects.
REQ-015 In RUN, the block SHALL accept one update per cycle with no backpressure.
REQ-016 In the pipeline, S1 SHALL register the accepted update and assert o_state_ren with raddr=prod_id.
REQ-017 In the pipeline, S2 SHALL combine rdata or forwarded data with the command.
REQ-018 In the pipeline, S3 SHALL register the write and response outputs; an update accepted at edge t SHALL produce wen and rsp_vld at edge t+3.
REQ-019 For every accepted update, the block SHALL produce exactly one write and one response, in acceptance order.
REQ-020 For cmd 00 (CLR), the new entry SHALL be all-zero; hit SHALL be the old vld; err SHALL be 0.
REQ-021 For cmd 01 (ADD), the new entry SHALL be {1, key, size}; hit SHALL be old vld with key match; err SHALL be 0.
REQ-022 For cmd 10 (INC), on hit the new size SHALL be old size + size, saturating at 2^SIZE_W-1; on miss the entry SHALL be unchanged and err=1.
REQ-023 For cmd 11 (DEC), on hit the new size SHALL be old size - size, saturating at 0; a result of 0 SHALL clear the entry to all-zero; on miss the entry SHALL be unchanged and err=1.
REQ-024 rsp_size SHALL carry the new entry's size field; an unchanged entry SHALL still be written back.
REQ-025 For hazard forwarding, when the S2 prod_id equals the S3 waddr with wen set, S2 SHALL use the S3 wdata.
REQ-026 For hazard forwarding, otherwise, when the S2 prod_id equals the address in a one-deep last-write register (holding the previous cycle's S3 write), S2 SHALL use that data.
REQ-027 For hazard forwarding, otherwise S2 SHALL use i_state_rdata; S3 SHALL take priority over the last-write register.
REQ-028 Back-to-back updates to the same id, at any spacing, SHALL yield results identical to serial execution.

Reset
REQ-029 While rst_n=0, all valid flops, o_state_wen_r, o_rsp_vld_r, o_err_sticky_r, o_upd_rdy and the init counter SHALL be 0, and the FSM SHALL be in INIT; data flops need no reset.
REQ-030 On reset assertion mid-operation, the block SHALL discard in-flight updates, and deassertion SHALL restart INIT from address 0.

Verification
REQ-031 The bench SHALL cover: reset release with ID_W=4 -> 16 writes of 0 to addresses 0..15 on consecutive cycles, then o_upd_rdy=1.
REQ-032 The bench SHALL cover: ADD id3 key 0xA5 size 10, then INC id3 key 0xA5 size 5 on the next cycle -> second response hit=1, size=15, with the forwarding path exercised.
REQ-033 The bench SHALL cover: INC id3 size 0xFFF0 on an entry of size 0x0020 with SIZE_W=16 -> size=0xFFFF.
REQ-034 The bench SHALL cover: DEC id3 size 20 on size 15 -> entry all-zero, hit=1; a following INC on id3 -> err=1, sticky=1.
REQ-035 The bench SHALL cover: ops on ids 1,2,1 in consecutive cycles -> the third op uses the last-write register for id1 and its result matches a serial model.
REQ-036 The bench SHALL cover: rst_n pulse with 3 ops in flight -> no write or response for those ops, and INIT restarts at address 0.
